// File: rtl/prescaler_pkg.sv
// Shared prescaler constants and the speed-code to limit function.
// Reused by the prescaler, its benches and other timing blocks.
package prescaler_pkg;

  localparam int unsigned CLK_FREQ_HZ_DEFAULT = 50_000_000;
  localparam int          CNT_W_DEFAULT       = 26;
  localparam int          SPEED_W             = 4;
  localparam int          NUM_SPEEDS          = 16;

  // Terminal count for speed code n: the period is freq/(n+1) cycles,
  // so the counter runs 0 .. floor(freq/(n+1))-1.
  function automatic int unsigned calc_limit(
    input int unsigned code,
    input int unsigned freq_hz
  );
    return (freq_hz / (code + 1)) - 1;
  endfunction

endpackage

// File: rtl/prescaler_limit_lut.sv
// Speed code -> terminal count table, fixed at elaboration.
// Ports: speed (code in), limit (terminal count out), purely combinational.
module prescaler_limit_lut
  import prescaler_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
  parameter int          CNT_W       = CNT_W_DEFAULT
) (
  input  logic [SPEED_W-1:0] speed,
  output logic [CNT_W-1:0]   limit
);

  logic [CNT_W-1:0] tbl [NUM_SPEEDS];

  // Every entry is a constant, so no divider is ever built and
  // every code maps to a defined value.
  for (genvar i = 0; i < NUM_SPEEDS; i++) begin : g_tbl
    localparam int unsigned LIM = calc_limit(i, CLK_FREQ_HZ);
    assign tbl[i] = CNT_W'(LIM);
  end

  assign limit = tbl[speed];

endmodule

// File: rtl/prescaler.sv
// Programmable tick generator: one-cycle tick_o at (speed_i+1) Hz.
// Ports: clk_i, rst_i (sync, active-high), speed_i[3:0], tick_o.
module prescaler
  import prescaler_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
  parameter int          CNT_W       = CNT_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SPEED_W-1:0] speed_i,
  output logic               tick_o
);

  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] cnt;
  logic             wrap;

  prescaler_limit_lut #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .CNT_W       (CNT_W)
  ) u_lut (
    .speed (speed_i),
    .limit (limit)
  );

  // >= rather than == so a switch to a faster speed while cnt is
  // already past the new limit ticks at once instead of overrunning.
  assign wrap = (cnt >= limit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else if (wrap) begin
      cnt    <= '0;
      tick_o <= 1'b1;
    end else begin
      cnt    <= cnt + CNT_W'(1);
      tick_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prescaler.sv
// Self-checking bench for prescaler, run at a scaled-down clock rate.
// Expected tick cycles are queued when stimulus is applied.
module tb_prescaler;
  import prescaler_pkg::*;

  localparam int unsigned F = 1000;
  localparam int W   = 26;
  localparam int L0  = 999;
  localparam int L2  = 332;
  localparam int L7  = 124;
  localparam int L15 = 61;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] speed = 4'd7;
  logic       tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_zero = 0;
  int got;
  int exp_q[$];
  logic prev_tick = 1'b0;

  prescaler #(
    .CLK_FREQ_HZ (F),
    .CNT_W       (W)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .speed_i (speed),
    .tick_o  (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard side: every observed tick must match the head of the queue.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: tick at cycle %0d, none expected", cyc);
      end else begin
        got = exp_q.pop_front();
        if (cyc !== got) begin
          errors++;
          $display("FAIL tick_time: tick at cycle %0d, required %0d", cyc, got);
        end
      end
      checks++;
      if (prev_tick !== 1'b0) begin
        errors++;
        $display("FAIL tick_width: tick high 2 cycles at %0d, required 1", cyc);
      end
    end
    prev_tick = tick;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Queue n further ticks at a fixed limit from the last counter zero.
  task automatic sched(input int lim, input int n);
    for (int k = 0; k < n; k++) begin
      t_zero = t_zero + lim + 1;
      exp_q.push_back(t_zero);
    end
  endtask

  // Change speed at a negedge and queue the first tick under the new limit.
  task automatic change_speed(input logic [3:0] code, input int lim);
    int c;
    @(negedge clk);
    speed = code;
    c = cyc - t_zero;
    if (c >= lim) t_zero = cyc + 1;
    else t_zero = t_zero + lim + 1;
    exp_q.push_back(t_zero);
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d ticks still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_pkg_limits();
    int unsigned r;
    r = calc_limit(0, CLK_FREQ_HZ_DEFAULT);
    checks++;
    if (r !== 32'd49_999_999) begin
      errors++; $display("FAIL pkg_lim0: got %0d, required 49999999", r);
    end
    r = calc_limit(2, CLK_FREQ_HZ_DEFAULT);
    checks++;
    if (r !== 32'd16_666_665) begin
      errors++; $display("FAIL pkg_lim2: got %0d, required 16666665", r);
    end
    r = calc_limit(7, CLK_FREQ_HZ_DEFAULT);
    checks++;
    if (r !== 32'd6_249_999) begin
      errors++; $display("FAIL pkg_lim7: got %0d, required 6249999", r);
    end
    r = calc_limit(15, CLK_FREQ_HZ_DEFAULT);
    checks++;
    if (r !== 32'd3_124_999) begin
      errors++; $display("FAIL pkg_lim15: got %0d, required 3124999", r);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (tick !== 1'b0) begin
        errors++; $display("FAIL reset_tick: got %b, required 0", tick);
      end
      checks++;
      if (dut.cnt !== '0) begin
        errors++; $display("FAIL reset_cnt: got %0d, required 0", dut.cnt);
      end
    end
  endtask

  task automatic test_release_8hz();
    rst = 1'b0;
    t_zero = cyc;
    checks++;
    if (dut.limit !== W'(L7)) begin
      errors++; $display("FAIL limit7: got %0d, required %0d", dut.limit, L7);
    end
    sched(L7, 2);
    wait_drain("release_8hz");
  endtask

  task automatic test_speed_up();
    repeat (20) @(negedge clk);
    change_speed(4'd15, L15);
    sched(L15, 2);
    wait_drain("speed_up");
  endtask

  task automatic test_slowest();
    change_speed(4'd0, L0);
    @(negedge clk);
    checks++;
    if (dut.limit !== W'(L0)) begin
      errors++; $display("FAIL limit0: got %0d, required %0d", dut.limit, L0);
    end
    sched(L0, 1);
    wait_drain("slowest");
  endtask

  task automatic test_speed2();
    change_speed(4'd2, L2);
    @(negedge clk);
    checks++;
    if (dut.limit !== W'(L2)) begin
      errors++; $display("FAIL limit2: got %0d, required %0d", dut.limit, L2);
    end
    sched(L2, 1);
    wait_drain("speed2");
  endtask

  task automatic test_fast_switch();
    int guard = 0;
    @(negedge clk);
    speed = 4'd0;
    while ((cyc - t_zero) < 800 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    change_speed(4'd15, L15);
    checks++;
    if (t_zero !== cyc + 1) begin
      errors++; $display("FAIL switch_at: cnt %0d, required 800", cyc - t_zero);
    end
    @(negedge clk);
    checks++;
    if (dut.cnt !== '0) begin
      errors++; $display("FAIL wrap_cnt: got %0d, required 0", dut.cnt);
    end
    sched(L15, 2);
    wait_drain("fast_switch");
  endtask

  task automatic test_reset_midcount();
    repeat (30) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tick !== 1'b0) begin
        errors++; $display("FAIL midrst_tick: got %b, required 0", tick);
      end
      checks++;
      if (dut.cnt !== '0) begin
        errors++; $display("FAIL midrst_cnt: got %0d, required 0", dut.cnt);
      end
    end
    rst = 1'b0;
    t_zero = cyc;
    sched(L15, 1);
    wait_drain("after_midrst");
  endtask

  initial begin
    test_pkg_limits();
    test_reset();
    test_release_8hz();
    test_speed_up();
    test_slowest();
    test_speed2();
    test_fast_switch();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescaler.md
Name: prescaler

Overview:
Programmable tick generator. It divides the system clock (50 MHz nominal) down to a single-cycle enable pulse, tick_o. The pulse rate is selected by a 4-bit speed code, from 1 Hz to 16 Hz in 1 Hz steps. The pulse paces the LED-spinner animation logic downstream.

Parameters:
CLK_FREQ_HZ, 50_000_000, input clock frequency in Hz; used to derive the per-speed limits at elaboration.
CNT_W, 26, counter and limit width in bits; must hold CLK_FREQ_HZ-1.

Ports:
clk_i  input  1  system clock, rising-edge active
rst_i  input  1  reset, synchronous, active-high
speed_i  input  4  speed code n; tick rate = n+1 Hz (0 -> 1 Hz, 7 -> 8 Hz, 15 -> 16 Hz)
tick_o  output  1  registered one-clock-wide pulse at the selected rate

Behaviour:
- One clock domain (clk_i). Reset is synchronous and active-high on rst_i.
- Internal signal limit [CNT_W-1:0] is combinational from speed_i: limit = floor(CLK_FREQ_HZ/(n+1)) - 1.
  - Implemented as a 16-entry constant lookup computed at elaboration. No runtime divider.
  - At default clock: n=0 -> 49_999_999; n=2 -> 16_666_665; n=7 -> 6_249_999; n=15 -> 3_124_999.
- Internal counter cnt [CNT_W-1:0].
- Every rising clk_i edge, in priority order:
  - rst_i=1: cnt <= 0, tick_o <= 0.
  - else if cnt >= limit: cnt <= 0, tick_o <= 1.
  - else: cnt <= cnt+1, tick_o <= 0.
- Period is limit+1 cycles. tick_o is high for exactly one cycle per period.
- First tick after reset release: the counter starts from 0, so tick_o first rises at the (limit+1)-th edge after the first non-reset edge. At 8 Hz this is 6_250_000 cycles = 125 ms.
- speed_i change mid-count takes effect immediately. There is no restart and no resync.
  - If cnt < new limit: counting continues to the new limit.
  - If cnt >= new limit: tick on the next edge, then wrap to 0. No counter overflow and no lost tick.
- speed_i is used as-is; the source must be synchronous to clk_i.
- Reset asserted mid-count: cnt and tick_o clear on the next edge, and any pending tick is discarded.
- No X propagation: every code of speed_i maps to a defined limit.

Decomposition:
- Shared package: constant CLK_FREQ_HZ_DEFAULT=50_000_000 and a function computing the limit from speed code and clock frequency. The same constants are reused by benches and other timing blocks.
- An optional sub-module prescaler_limit_lut (speed_i -> limit, purely combinational) isolates the table.
- Counter and tick register stay in prescaler.

Test Plan:
1. rst_i=1 for 5 cycles, speed_i=7 -> tick_o=0 and cnt=0 throughout reset.
2. Release reset, speed_i=7 -> ticks at exactly 125 ms and 250 ms after release, each 1 cycle (20 ns) wide; spacing 6_250_000 cycles.
3. After scenario 2, at ~270 ms set speed_i=15 -> subsequent tick spacing 3_125_000 cycles (62.5 ms). The next tick occurs when cnt reaches 3_124_999 (or immediately if cnt was already at or above it).
4. speed_i=0 -> tick spacing 50_000_000 cycles (1 s); limit reads 49_999_999.
5. speed_i=2 -> limit 16_666_665, spacing 16_666_666 cycles.
6. Switch 0 -> 15 while cnt = 40_000_000 -> tick_o high on the next edge, cnt wraps to 0, then regular 3_125_000-cycle spacing. Asserting rst_i mid-count -> no tick and cnt=0 next cycle.
